// File: rtl/mem_pkg.sv
// Shared types and defaults for the pipelined data memory.
// Holds the FSM encoding, default geometry and the read-response record.
package mem_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    localparam int DEF_DW     = 8;
    localparam int DEF_DEPTH  = 32;
    localparam int MAX_RD_LAT = 4;

    typedef struct packed {
        logic              valid;
        logic              err;
        logic [DEF_DW-1:0] data;
    } rsp_t;

endpackage

// File: rtl/pipelined_data_mem_rd_pipe.sv
// Read-response shift register, RD_LAT stages of {valid, err, data}.
// Data only advances with a valid entry so the last stage holds between responses.
module rd_pipe #(
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          in_valid_i,
    input  logic          in_err_i,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    output logic          out_err_o,
    output logic [DW-1:0] out_data_o
);

    typedef struct packed {
        logic          valid;
        logic          err;
        logic [DW-1:0] data;
    } stage_t;

    stage_t stage_q [RD_LAT];
    stage_t feed_s  [RD_LAT];

    // Input of each stage: new request for stage 0, previous stage otherwise.
    always_comb begin
        feed_s[0].valid = in_valid_i;
        feed_s[0].err   = in_err_i;
        feed_s[0].data  = in_data_i;
        for (int i = 1; i < RD_LAT; i++) begin
            feed_s[i] = stage_q[i-1];
        end
    end

    // Shift every cycle; err is forced low whenever the entry is not valid.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage_q[i].valid <= feed_s[i].valid;
                stage_q[i].err   <= feed_s[i].valid & feed_s[i].err;
                if (feed_s[i].valid) begin
                    stage_q[i].data <= feed_s[i].data;
                end
            end
        end
    end

    assign out_valid_o = stage_q[RD_LAT-1].valid;
    assign out_err_o   = stage_q[RD_LAT-1].err;
    assign out_data_o  = stage_q[RD_LAT-1].data;

endmodule

// File: rtl/pipelined_data_mem.sv
// Handshake-driven single-port data memory with pipelined reads and a
// hardware clear sweep after reset and on request.
module pipelined_data_mem
    import mem_pkg::*;
#(
    parameter int            DW      = DEF_DW,
    parameter int            DEPTH   = DEF_DEPTH,
    parameter int            AW      = 5,
    parameter int            RD_LAT  = 1,
    parameter logic [DW-1:0] CLR_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_adr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          busy
);

    localparam logic [AW-1:0] LAST_ADR = AW'(DEPTH - 1);
    localparam logic [31:0]   DEPTH_W  = 32'(DEPTH);

    state_e        state_q;
    logic [AW-1:0] cnt_q;
    logic          req_ready_q;
    logic          busy_q;
    logic [DW-1:0] mem_q [DEPTH];

    logic          accept_s;
    logic          in_range_s;
    logic          rd_fire_s;
    logic          rd_err_s;
    logic [DW-1:0] rd_data_s;

    // Request decode; out-of-range reads return zero and flag an error.
    always_comb begin
        accept_s   = req_valid & req_ready_q;
        in_range_s = (32'(req_adr) < DEPTH_W);
        rd_fire_s  = accept_s & ~req_write;
        rd_err_s   = ~in_range_s;
        if (in_range_s) begin
            rd_data_s = mem_q[req_adr];
        end else begin
            rd_data_s = '0;
        end
    end

    // Control FSM: an accepted request takes priority over a clear request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (cnt_q == LAST_ADR) begin
                        state_q     <= ST_IDLE;
                        cnt_q       <= '0;
                        req_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        cnt_q       <= cnt_q + AW'(1);
                    end
                end
                ST_IDLE: begin
                    if (clr_req && !accept_s) begin
                        state_q     <= ST_CLEAR;
                        cnt_q       <= '0;
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_CLEAR;
                    cnt_q       <= '0;
                    req_ready_q <= 1'b0;
                    busy_q      <= 1'b1;
                end
            endcase
        end
    end

    // Storage array: contents come only from the sweep or accepted writes.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem_q[cnt_q] <= CLR_VAL;
        end else if (accept_s && req_write && in_range_s) begin
            mem_q[req_adr] <= req_wdata;
        end
    end

    rd_pipe #(
        .DW     (DW),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk_i       (clk),
        .rst_ni      (rst),
        .in_valid_i  (rd_fire_s),
        .in_err_i    (rd_err_s),
        .in_data_i   (rd_data_s),
        .out_valid_o (rsp_valid),
        .out_err_o   (rsp_err),
        .out_data_o  (rsp_rdata)
    );

    assign req_ready = req_ready_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_pipelined_data_mem.sv
// Directed bench: instance A uses defaults (DEPTH 32, RD_LAT 1, CLR 0x00),
// instance B uses DEPTH 20, RD_LAT 3, CLR 0xFF.
module tb_pipelined_data_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst_v, clr_v, vld_v, wr_v;
    logic [4:0] adr_v [2];
    logic [7:0] wd_v  [2];
    logic [1:0] rdy_v, val_v, err_v, busy_v;
    logic [7:0] rdata_v [2];

    int n_checks = 0;
    int n_fail   = 0;

    pipelined_data_mem u_a (
        .clk(clk), .rst(rst_v[0]), .clr_req(clr_v[0]),
        .req_valid(vld_v[0]), .req_ready(rdy_v[0]), .req_write(wr_v[0]),
        .req_adr(adr_v[0]), .req_wdata(wd_v[0]),
        .rsp_valid(val_v[0]), .rsp_rdata(rdata_v[0]), .rsp_err(err_v[0]),
        .busy(busy_v[0])
    );

    pipelined_data_mem #(
        .DW(8), .DEPTH(20), .AW(5), .RD_LAT(3), .CLR_VAL(8'hFF)
    ) u_b (
        .clk(clk), .rst(rst_v[1]), .clr_req(clr_v[1]),
        .req_valid(vld_v[1]), .req_ready(rdy_v[1]), .req_write(wr_v[1]),
        .req_adr(adr_v[1]), .req_wdata(wd_v[1]),
        .rsp_valid(val_v[1]), .rsp_rdata(rdata_v[1]), .rsp_err(err_v[1]),
        .busy(busy_v[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_write(input int s, input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        vld_v[s] = 1'b1; wr_v[s] = 1'b1; adr_v[s] = a; wd_v[s] = d;
        @(negedge clk);
        vld_v[s] = 1'b0; wr_v[s] = 1'b0;
    endtask

    task automatic do_read(input int s, input logic [4:0] a,
                           output logic [7:0] d, output logic e, output int lat);
        @(negedge clk);
        vld_v[s] = 1'b1; wr_v[s] = 1'b0; adr_v[s] = a;
        @(negedge clk);
        vld_v[s] = 1'b0;
        lat = 1;
        while (!val_v[s] && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        d = rdata_v[s];
        e = err_v[s];
    endtask

    // Counts busy samples; flags ready or a response seen during the sweep.
    task automatic wait_idle(input int s, output int n, output int bad);
        n = 0; bad = 0;
        while (busy_v[s] && n < 100) begin
            if (rdy_v[s] || val_v[s]) bad++;
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [7:0] d;
        logic       e;
        int         lat, n0, n1, b0, b1, seen;
        logic [7:0] exp_b2b [4];

        exp_b2b[0] = 8'd7; exp_b2b[1] = 8'd10; exp_b2b[2] = 8'd3; exp_b2b[3] = 8'd22;
        rst_v = 2'b00; clr_v = 2'b00; vld_v = 2'b00; wr_v = 2'b00;
        for (int i = 0; i < 2; i++) begin
            adr_v[i] = 5'd0; wd_v[i] = 8'd0;
        end

        repeat (3) @(negedge clk);
        check_eq("rst_busy",  32'(busy_v[0]),  32'd1);
        check_eq("rst_ready", 32'(rdy_v[0]),   32'd0);
        check_eq("rst_valid", 32'(val_v),      32'd0);
        check_eq("rst_rdata", 32'(rdata_v[0]), 32'd0);
        check_eq("rst_err",   32'(err_v),      32'd0);

        rst_v = 2'b11;
        #1;
        fork
            wait_idle(0, n0, b0);
            wait_idle(1, n1, b1);
        join
        check_eq("a_sweep_len", 32'(n0), 32'd32);
        check_eq("a_sweep_bad", 32'(b0), 32'd0);
        check_eq("b_sweep_len", 32'(n1), 32'd20);
        check_eq("b_sweep_bad", 32'(b1), 32'd0);

        // Instance A: cleared contents at both ends and the middle.
        do_read(0, 5'd0, d, e, lat);
        check_eq("a_rd0", {23'd0, e, d}, 32'h000);  check_eq("a_rd0_lat", 32'(lat), 32'd1);
        do_read(0, 5'd15, d, e, lat);
        check_eq("a_rd15", {23'd0, e, d}, 32'h000); check_eq("a_rd15_lat", 32'(lat), 32'd1);
        do_read(0, 5'd31, d, e, lat);
        check_eq("a_rd31", {23'd0, e, d}, 32'h000); check_eq("a_rd31_lat", 32'(lat), 32'd1);

        // Read-after-write on consecutive accept edges.
        @(negedge clk);
        vld_v[0] = 1'b1; wr_v[0] = 1'b1; adr_v[0] = 5'd15; wd_v[0] = 8'h07;
        @(negedge clk);
        wr_v[0] = 1'b0;
        @(negedge clk);
        vld_v[0] = 1'b0;
        check_eq("a_raw_valid", 32'(val_v[0]),  32'd1);
        check_eq("a_raw_data",  32'(rdata_v[0]), 32'h07);
        @(negedge clk);
        check_eq("a_pulse_drop", 32'(val_v[0]),  32'd0);
        check_eq("a_rdata_hold", 32'(rdata_v[0]), 32'h07);

        // Instance B: swept to 0xFF, then back-to-back reads at latency 3.
        do_read(1, 5'd0, d, e, lat);
        check_eq("b_rd0", 32'(d), 32'hFF); check_eq("b_rd0_lat", 32'(lat), 32'd3);
        do_write(1, 5'd15, 8'd7);
        do_write(1, 5'd16, 8'd10);
        do_write(1, 5'd17, 8'd3);
        do_write(1, 5'd18, 8'd22);
        @(negedge clk);
        vld_v[1] = 1'b1; wr_v[1] = 1'b0; adr_v[1] = 5'd15;
        for (int c = 1; c < 10; c++) begin
            @(negedge clk);
            check_eq($sformatf("b_b2b_v%0d", c), 32'(val_v[1]), (c >= 3 && c <= 6) ? 32'd1 : 32'd0);
            if (c >= 3 && c <= 6)
                check_eq($sformatf("b_b2b_d%0d", c), 32'(rdata_v[1]), 32'(exp_b2b[c-3]));
            if (c < 4) adr_v[1] = 5'(15 + c);
            else       vld_v[1] = 1'b0;
        end

        // Out-of-range write is dropped; out-of-range read flags an error.
        do_write(1, 5'd25, 8'hAA);
        do_read(1, 5'd25, d, e, lat);
        check_eq("b_oor_err",  32'(e),   32'd1);
        check_eq("b_oor_data", 32'(d),   32'd0);
        check_eq("b_oor_lat",  32'(lat), 32'd3);
        @(negedge clk);
        check_eq("b_err_idle", 32'(err_v[1]), 32'd0);
        do_read(1, 5'd5, d, e, lat);
        check_eq("b_alias5", {23'd0, e, d}, 32'h0FF);
        do_read(1, 5'd9, d, e, lat);
        check_eq("b_alias9", {23'd0, e, d}, 32'h0FF);
        do_read(1, 5'd16, d, e, lat);
        check_eq("b_keep16", 32'(d), 32'd10);

        // On-demand clear sweep.
        do_write(1, 5'd3, 8'h55);
        do_read(1, 5'd3, d, e, lat);
        check_eq("b_pre_clr", 32'(d), 32'h55);
        @(negedge clk);
        clr_v[1] = 1'b1;
        @(negedge clk);
        clr_v[1] = 1'b0;
        wait_idle(1, n1, b1);
        check_eq("b_clr_len", 32'(n1), 32'd20);
        check_eq("b_clr_bad", 32'(b1), 32'd0);
        do_read(1, 5'd3, d, e, lat);
        check_eq("b_post_clr", 32'(d), 32'hFF);

        // Clear request coinciding with an accepted write is not taken.
        @(negedge clk);
        clr_v[1] = 1'b1; vld_v[1] = 1'b1; wr_v[1] = 1'b1; adr_v[1] = 5'd4; wd_v[1] = 8'h33;
        @(negedge clk);
        clr_v[1] = 1'b0; vld_v[1] = 1'b0; wr_v[1] = 1'b0;
        check_eq("b_clr_vs_req_busy", 32'(busy_v[1]), 32'd0);
        do_read(1, 5'd4, d, e, lat);
        check_eq("b_clr_vs_req_data", 32'(d), 32'h33);

        // Reset with two reads in flight: both are discarded.
        @(negedge clk);
        vld_v[1] = 1'b1; wr_v[1] = 1'b0; adr_v[1] = 5'd4;
        @(negedge clk);
        @(negedge clk);
        vld_v[1] = 1'b0;
        rst_v[1] = 1'b0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (val_v[1]) seen++;
        end
        check_eq("b_rst_flight", 32'(seen), 32'd0);
        check_eq("b_rst_busy", 32'(busy_v[1]), 32'd1);
        rst_v[1] = 1'b1;
        #1;
        wait_idle(1, n1, b1);
        check_eq("b_rst_sweep_len", 32'(n1), 32'd20);
        check_eq("b_rst_sweep_bad", 32'(b1), 32'd0);
        do_read(1, 5'd4, d, e, lat);
        check_eq("b_rst_data", 32'(d), 32'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
